// File: rtl/img_pkg.sv
// Shared constants for the 3x3 window generator: default pixel width, tap indices
// and the coordinate-width helper.
package img_pkg;

    localparam int PIX_W_DEF = 8;

    // Tap order: row-major, top row is the oldest line, right column is the newest pixel.
    localparam int TAP_TL   = 0;
    localparam int TAP_TM   = 1;
    localparam int TAP_TR   = 2;
    localparam int TAP_ML   = 3;
    localparam int TAP_MM   = 4;
    localparam int TAP_MR   = 5;
    localparam int TAP_BL   = 6;
    localparam int TAP_BM   = 7;
    localparam int TAP_BR   = 8;
    localparam int NUM_TAPS = 9;

    function automatic int coord_w(input int n);
        return (n > 2) ? $clog2(n) : 2;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: single address, combinational read of the old word,
// write on the clock edge. Contents are never reset.
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator: two line buffers plus a 3x3 shift window.
// Optional macro WINDOW_ZERO_BORDER_EN widens emission to col>=1/row>=1 with zeroed outside taps.
module window_3x3_gen
    import img_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic             out_sof,
    output logic [PIX_W-1:0] p0,
    output logic [PIX_W-1:0] p1,
    output logic [PIX_W-1:0] p2,
    output logic [PIX_W-1:0] p3,
    output logic [PIX_W-1:0] p4,
    output logic [PIX_W-1:0] p5,
    output logic [PIX_W-1:0] p6,
    output logic [PIX_W-1:0] p7,
    output logic [PIX_W-1:0] p8
);

    localparam int CW = coord_w(IMG_WIDTH);
    localparam int RW = coord_w(IMG_HEIGHT);

    logic [CW-1:0]    r_col, w_cur_col, w_next_col;
    logic [RW-1:0]    r_row, w_cur_row, w_next_row;
    logic [PIX_W-1:0] w_lb1_rd, w_lb2_rd;
    logic [PIX_W-1:0] r_win     [NUM_TAPS];
    logic [PIX_W-1:0] w_win_nxt [NUM_TAPS];
    logic [PIX_W-1:0] w_tap_nxt [NUM_TAPS];
    logic [PIX_W-1:0] r_tap     [NUM_TAPS];
    logic             r_out_valid, r_out_sof;
    logic             w_emit, w_first;

    // in_sof forces the accepted pixel to (0,0) whatever the counters say.
    always_comb begin
        w_cur_col  = in_sof ? '0 : r_col;
        w_cur_row  = in_sof ? '0 : r_row;
        w_next_col = w_cur_col + 1'b1;
        w_next_row = w_cur_row;
        if (w_cur_col == CW'(IMG_WIDTH - 1)) begin
            w_next_col = '0;
            w_next_row = (w_cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : w_cur_row + 1'b1;
        end
    end

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb1 (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_cur_col),
        .i_wdata (in_pixel),
        .o_rdata (w_lb1_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W), .AW(CW)) u_lb2 (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_cur_col),
        .i_wdata (w_lb1_rd),
        .o_rdata (w_lb2_rd)
    );

    always_comb begin
        w_win_nxt[TAP_TL] = r_win[TAP_TM];
        w_win_nxt[TAP_TM] = r_win[TAP_TR];
        w_win_nxt[TAP_TR] = w_lb2_rd;
        w_win_nxt[TAP_ML] = r_win[TAP_MM];
        w_win_nxt[TAP_MM] = r_win[TAP_MR];
        w_win_nxt[TAP_MR] = w_lb1_rd;
        w_win_nxt[TAP_BL] = r_win[TAP_BM];
        w_win_nxt[TAP_BM] = r_win[TAP_BR];
        w_win_nxt[TAP_BR] = in_pixel;
    end

`ifdef WINDOW_ZERO_BORDER_EN
    // Left column / top row fall outside the image on the first emitted column / row.
    always_comb begin
        w_emit  = in_valid && (w_cur_col >= CW'(1)) && (w_cur_row >= RW'(1));
        w_first = (w_cur_col == CW'(1)) && (w_cur_row == RW'(1));
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_tap_nxt[i] = w_win_nxt[i];
        end
        if (w_cur_col == CW'(1)) begin
            w_tap_nxt[TAP_TL] = '0;
            w_tap_nxt[TAP_ML] = '0;
            w_tap_nxt[TAP_BL] = '0;
        end
        if (w_cur_row == RW'(1)) begin
            w_tap_nxt[TAP_TL] = '0;
            w_tap_nxt[TAP_TM] = '0;
            w_tap_nxt[TAP_TR] = '0;
        end
    end
`else
    always_comb begin
        w_emit  = in_valid && (w_cur_col >= CW'(2)) && (w_cur_row >= RW'(2));
        w_first = (w_cur_col == CW'(2)) && (w_cur_row == RW'(2));
        for (int i = 0; i < NUM_TAPS; i++) begin
            w_tap_nxt[i] = w_win_nxt[i];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_win[i] <= '0;
                r_tap[i] <= '0;
            end
        end else begin
            r_out_valid <= w_emit;
            r_out_sof   <= w_emit && w_first;
            if (in_valid) begin
                r_col <= w_next_col;
                r_row <= w_next_row;
                for (int i = 0; i < NUM_TAPS; i++) begin
                    r_win[i] <= w_win_nxt[i];
                end
            end
            // Taps only change on a strobe, so they hold across input gaps.
            if (w_emit) begin
                for (int i = 0; i < NUM_TAPS; i++) begin
                    r_tap[i] <= w_tap_nxt[i];
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign p0 = r_tap[TAP_TL];
    assign p1 = r_tap[TAP_TM];
    assign p2 = r_tap[TAP_TR];
    assign p3 = r_tap[TAP_ML];
    assign p4 = r_tap[TAP_MM];
    assign p5 = r_tap[TAP_MR];
    assign p6 = r_tap[TAP_BL];
    assign p7 = r_tap[TAP_BM];
    assign p8 = r_tap[TAP_BR];

endmodule
